// File: rtl/paralelo_serial_tx_pkg.sv
// rtl/paralelo_serial_tx_pkg.sv - shared symbol constants and encodings for the serial lane
// Purpose: symbol values, default training length, control-state and symbol-select
//          encodings. The receive-side IDLE detector imports the same package.
// Ports:   none (package)
package paralelo_serial_tx_pkg;

    localparam logic [7:0]  SYM_COM       = 8'hBC;
    localparam logic [7:0]  SYM_IDLE      = 8'h7C;
    localparam int unsigned DEF_COM_COUNT = 4;

    typedef enum logic {
        ST_TRAIN  = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SEL_COM  = 2'd0,
        SEL_DATA = 2'd1,
        SEL_IDLE = 2'd2
    } sym_sel_t;

endpackage

// File: rtl/paralelo_serial_tx_if.sv
// rtl/paralelo_serial_tx_if.sv - byte handshake between upstream source and serializer
// Purpose: groups the valid/ready byte handshake feeding the serializer.
// Signals: data_in   byte to send (source -> serializer)
//          valid_in  data_in holds a byte (source -> serializer)
//          ready_out next symbol slot accepts a byte (serializer -> source)
interface paralelo_serial_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             ready_out;

    modport master (output data_in, output valid_in, input ready_out);
    modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/paralelo_serial_tx_simbolo_shifter.sv
// rtl/paralelo_serial_tx_simbolo_shifter.sv - symbol select and MSB-first shift register
// Purpose: picks COM, the accepted byte or IDLE on a load edge and shifts it out MSB-first.
// Ports:   clk_i       bit clock
//          rst_ni      asynchronous active-low reset
//          load_i      load a new symbol on this edge
//          sel_i       which symbol to load
//          data_i      accepted byte (used when sel_i == SEL_DATA)
//          serial_o    serial lane
//          sym_start_o high while serial_o carries bit7 of a symbol
//          bit_cnt_o   index of the bit currently on serial_o (0 = MSB)
module simbolo_shifter
    import paralelo_serial_tx_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] COM_SYMBOL  = SYM_COM,
    parameter logic [WIDTH-1:0] IDLE_SYMBOL = SYM_IDLE
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  sym_sel_t         sel_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             serial_o,
    output logic             sym_start_o,
    output logic [2:0]       bit_cnt_o
);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] sym;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic             sym_start_q, sym_start_d;

    always_comb begin
        sym = IDLE_SYMBOL;
        case (sel_i)
            SEL_COM:  sym = COM_SYMBOL;
            SEL_DATA: sym = data_i;
            default:  sym = IDLE_SYMBOL;
        endcase
    end

    always_comb begin
        sr_d        = {sr_q[WIDTH-2:0], 1'b0};
        bit_cnt_d   = bit_cnt_q + 3'd1;
        sym_start_d = 1'b0;
        if (load_i) begin
            sr_d        = sym;
            bit_cnt_d   = 3'd0;
            sym_start_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q        <= '0;
            bit_cnt_q   <= 3'd0;
            sym_start_q <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            sym_start_q <= sym_start_d;
        end
    end

    assign serial_o    = sr_q[WIDTH-1];
    assign sym_start_o = sym_start_q;
    assign bit_cnt_o   = bit_cnt_q;

endmodule

// File: rtl/paralelo_serial_tx.sv
// rtl/paralelo_serial_tx.sv - byte-to-serial transmitter with COM training and IDLE fill
// Purpose: after reset sends COM_COUNT COM symbols, then streams accepted bytes or IDLE,
//          back-to-back, MSB-first, one bit per clock.
// Ports:   clk_1      serial bit clock
//          reset      asynchronous active-low reset
//          bus        byte handshake (data_in, valid_in, ready_out)
//          serial_out serial lane
//          sym_start  high while serial_out carries bit7 of a symbol
//          active_out training burst complete
module paralelo_serial_tx
    import paralelo_serial_tx_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] COM_SYMBOL  = SYM_COM,
    parameter logic [WIDTH-1:0] IDLE_SYMBOL = SYM_IDLE,
    parameter int unsigned      COM_COUNT   = DEF_COM_COUNT
) (
    input  logic                 clk_1,
    input  logic                 reset,
    paralelo_serial_tx_if.slave  bus,
    output logic                 serial_out,
    output logic                 sym_start,
    output logic                 active_out
);

    localparam logic [3:0] COM_CNT_MAX = 4'(COM_COUNT);

    state_t     state_q, state_d;
    logic [3:0] com_cnt_q, com_cnt_d;
    logic       started_q;
    logic       ready_q, ready_d;
    logic       active_q, active_d;
    logic [2:0] bit_cnt;
    logic       load;
    logic       accept;
    sym_sel_t   sel;

    // The very first edge after reset has bit_cnt == 0, so started_q forces that load.
    assign load   = !started_q || (bit_cnt == 3'd7);
    // ready_q is only ever high during bit 7, so it already implies a load edge.
    assign accept = bus.valid_in && ready_q;

    always_comb begin
        state_d   = state_q;
        com_cnt_d = com_cnt_q;
        active_d  = active_q;
        sel       = SEL_IDLE;
        ready_d   = 1'b0;
        if (load) begin
            if (state_q == ST_TRAIN) begin
                sel       = SEL_COM;
                com_cnt_d = com_cnt_q + 4'd1;
            end else begin
                active_d = 1'b1;
                sel      = accept ? SEL_DATA : SEL_IDLE;
            end
        end
        if (com_cnt_d == COM_CNT_MAX) begin
            state_d = ST_STREAM;
        end
        // Registered form of (bit_cnt==7 && com_cnt==COM_COUNT): bit 6 is about to become bit 7.
        ready_d = !load && (bit_cnt == 3'd6) && (state_d == ST_STREAM);
    end

    always_ff @(posedge clk_1 or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_TRAIN;
            com_cnt_q <= 4'd0;
            started_q <= 1'b0;
            ready_q   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            com_cnt_q <= com_cnt_d;
            started_q <= 1'b1;
            ready_q   <= ready_d;
            active_q  <= active_d;
        end
    end

    simbolo_shifter #(
        .WIDTH       (WIDTH),
        .COM_SYMBOL  (COM_SYMBOL),
        .IDLE_SYMBOL (IDLE_SYMBOL)
    ) u_shifter (
        .clk_i       (clk_1),
        .rst_ni      (reset),
        .load_i      (load),
        .sel_i       (sel),
        .data_i      (bus.data_in),
        .serial_o    (serial_out),
        .sym_start_o (sym_start),
        .bit_cnt_o   (bit_cnt)
    );

    assign bus.ready_out = ready_q;
    assign active_out    = active_q;

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// tb/tb_paralelo_serial_tx.sv - randomized bench for paralelo_serial_tx against a symbol-level model
module tb_paralelo_serial_tx;
    import paralelo_serial_tx_pkg::*;

    localparam int CC = 4;

    logic clk_1 = 1'b0;
    logic reset = 1'b0;
    logic serial_out;
    logic sym_start;
    logic active_out;

    paralelo_serial_tx_if #(.WIDTH(8)) bus();

    paralelo_serial_tx #(
        .WIDTH       (8),
        .COM_SYMBOL  (8'hBC),
        .IDLE_SYMBOL (8'h7C),
        .COM_COUNT   (CC)
    ) dut (
        .clk_1      (clk_1),
        .reset      (reset),
        .bus        (bus),
        .serial_out (serial_out),
        .sym_start  (sym_start),
        .active_out (active_out)
    );

    always #5 clk_1 = ~clk_1;

    int         vectors     = 0;
    int         miscompares = 0;
    int         k           = 0;
    logic [7:0] cur_sym     = 8'hBC;
    bit         accepted    = 1'b0;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, k, got, exp);
        end
    endtask

    function automatic logic [7:0] pick_byte();
        int r;
        r = $urandom_range(0, 5);
        if (r == 0) return 8'hBC;
        if (r == 1) return 8'h7C;
        return 8'($urandom);
    endfunction

    // Asynchronous reset between edges; outputs must clear at once. A byte whose
    // handshake edge has not yet happened stays pending upstream.
    task automatic apply_reset();
        #2 reset = 1'b0;
        #1;
        check_eq("rst_serial", 8'(serial_out), 8'd0);
        check_eq("rst_sym_start", 8'(sym_start), 8'd0);
        check_eq("rst_ready", 8'(bus.ready_out), 8'd0);
        check_eq("rst_active", 8'(active_out), 8'd0);
        accepted = 1'b0;
        repeat (3) @(negedge clk_1);
        reset   = 1'b1;
        k       = 0;
        cur_sym = 8'hBC;
    endtask

    // Model: cycle k carries bit (k%8) of symbol k/8. The first CC symbols are COM;
    // every later symbol is the byte offered during its predecessor's last bit, else IDLE.
    task automatic run_cycles(input int n, input int pct);
        int bit_i;
        for (int c = 0; c < n; c++) begin
            @(negedge clk_1);
            bit_i = k % 8;
            check_eq("serial", 8'(serial_out), 8'(cur_sym[7 - bit_i]));
            check_eq("sym_start", 8'(sym_start), 8'(bit_i == 0));
            check_eq("ready", 8'(bus.ready_out), 8'((bit_i == 7) && (k >= 8 * CC - 1)));
            check_eq("active", 8'(active_out), 8'(k >= 8 * CC));
            if (accepted) begin
                bus.valid_in = 1'b0;
                accepted     = 1'b0;
            end
            if (bit_i == 7) begin
                if (k < 8 * CC - 1) begin
                    cur_sym = 8'hBC;
                end else if (bus.valid_in) begin
                    cur_sym  = bus.data_in;
                    accepted = 1'b1;
                end else begin
                    cur_sym = 8'h7C;
                end
            end
            if (!bus.valid_in && ($urandom_range(0, 99) < pct)) begin
                bus.valid_in = 1'b1;
                bus.data_in  = pick_byte();
            end
            k++;
        end
    endtask

    initial begin
        bus.valid_in = 1'b0;
        bus.data_in  = 8'h00;
        @(negedge clk_1);
        apply_reset();
        run_cycles(48, 0);
        apply_reset();
        run_cycles(30, 0);
        bus.valid_in = 1'b1;
        bus.data_in  = 8'hA5;
        run_cycles(2, 0);
        apply_reset();
        run_cycles(200, 50);
        run_cycles(37, 30);
        apply_reset();
        run_cycles(250, 20);
        run_cycles(150, 100);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/paralelo_serial_tx.md
# paralelo_serial_tx

Transmit-side serializer that drives the serial lane consumed by the receive-side serial-to-parallel IDLE detector. It accepts bytes through a valid/ready handshake and shifts them out MSB-first, one bit per clock. After every reset it sends a training burst of COM symbols. From then on it keeps the lane continuously filled: it sends IDLE symbols whenever no data byte is available, so the downstream detector can count COMs and then recognise IDLE.

## Interface
Parameters:
- WIDTH, 8, symbol width in bits; only 8 is supported.
- COM_SYMBOL, 8'hBC, training symbol (bit7=1, bit6=0).
- IDLE_SYMBOL, 8'h7C, fill symbol.
- COM_COUNT, 4, number of COM symbols sent after reset; legal range 1..15.

Ports:
- clk_1  input  1  serial bit clock. There is one clock only; all logic runs on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  WIDTH  byte to send; sampled only on the accept edge.
- valid_in  input  1  data_in holds a byte.
- ready_out  output  1  the next symbol slot is a stream slot and a byte may be accepted.
- serial_out  output  1  serial lane, MSB-first.
- sym_start  output  1  high while serial_out carries bit7 of a symbol.
- active_out  output  1  the training burst is complete.

## Operation
- States:
  - TRAIN: loads COM_SYMBOL; com_cnt counts the COMs loaded.
  - STREAM: loads either the accepted byte or IDLE_SYMBOL.
- Datapath:
  - 8-bit shift register sr.
  - 3-bit bit_cnt.
  - 4-bit com_cnt, which saturates at COM_COUNT.
- Symbol load occurs on the first edge after reset release and on every edge where bit_cnt==7.
- Next-symbol selection at a load edge:
  - If com_cnt < COM_COUNT: load COM and increment com_cnt.
  - Else if valid_in & ready_out: load data_in (accept).
  - Else: load IDLE_SYMBOL.
- Move to STREAM once com_cnt reaches COM_COUNT.
- ready_out = (bit_cnt==7) & (com_cnt==COM_COUNT), registered. It is therefore high during the last bit of the final COM and of every later symbol.
- A byte is consumed only on the edge where valid_in & ready_out. If valid_in is high while ready_out is low, the byte is held upstream and not consumed.
- Bytes equal to COM_SYMBOL or IDLE_SYMBOL are sent verbatim; there is no escaping.
- active_out rises when the first STREAM symbol starts (sym_start of that symbol) and stays high until reset.
- Reset values: serial_out=0, ready_out=0, sym_start=0, active_out=0; internally sr=0, bit_cnt=0, com_cnt=0, state TRAIN.

## Timing
- Cycle k is the k-th rising edge after reset deasserts, with k starting at 0.
- Bit i of symbol n (i=0 is MSB) is driven on serial_out from edge 8n+i.
- Symbols are back-to-back with no gap cycles; the lane is never undriven after reset.
- Training occupies cycles 0..8·COM_COUNT−1. ready_out is first high at cycle 8·COM_COUNT−1.
- active_out goes high at cycle 8·COM_COUNT.
- Accept-to-first-bit latency is 1 cycle: a byte accepted at edge e appears as MSB from edge e+1.
- sym_start is high at cycles 0, 8, 16, ...; it is aligned with the bit_cnt==0 bit.
- Reset mid-operation:
  - All outputs clear immediately (asynchronous); any partial symbol is discarded.
  - After release, a full COM_COUNT burst is resent.
  - A byte handshaking at the instant of reset is not consumed.
- Reset released mid-cycle takes effect from the next rising edge, which is cycle 0.

## Structure
- Shared package or include holds COM_SYMBOL, IDLE_SYMBOL, the default COM_COUNT and the state encoding. The receive side uses the same package.
- The symbol-select plus shift register is one natural sub-module, `simbolo_shifter`: load, byte in, serial out, bit_cnt.
- The top level holds the TRAIN/STREAM control and the handshake.

## Test plan
- Reset release, valid_in=0, COM_COUNT=4 → cycles 0–31 show serial_out pattern 10111100 four times; cycles 32–39 show 01111100; active_out high from cycle 32; sym_start at 0, 8, 16, ...
- valid_in=1 with data_in=8'hA5 from reset → ready_out first high at cycle 31; cycles 32–39 show 10100101; no IDLE is inserted.
- Back-to-back bytes 8'h01, 8'h02, 8'h03, each presented on consecutive ready_out pulses (31, 39, 47) → cycles 32–55 carry the three bytes contiguously, followed by IDLE.
- valid_in raised at cycle 34 (not a ready edge) with 8'h3C held → accepted at cycle 39; cycles 32–39 show IDLE; cycles 40–47 show 00111100.
- Reset asserted at cycle 36 for 3 cycles → serial_out, ready_out and active_out are 0 immediately; after release, 4 COMs are resent starting at the new cycle 0; the pending byte is not consumed.
- data_in=8'hBC sent in STREAM → transmitted verbatim as 10111100; active_out stays 1; com_cnt is unchanged.
